// File: rtl/hedios_pkg.sv
// hedios_pkg: shared opcodes, packet widths, FSM states and saturating counter helper
package hedios_pkg;
   localparam int CMD_W = 8;
   localparam int DATA_W = 32;
   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;
   localparam logic [1:0] OP_PING = 2'b11;
   localparam logic [CMD_W-1:0] DEF_ERR_CMD = 8'hEE;
   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_EXEC, S_RESP} state_t;
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction
endpackage

// File: rtl/hedios_cmd_dispatch_if.sv
// hedios_cmd_dispatch_if: RX packet queue and TX response handshake bundle
interface hedios_cmd_dispatch_if;
   import hedios_pkg::*;
   logic              rx_empty;
   logic [CMD_W-1:0]  rx_command;
   logic [DATA_W-1:0] rx_data;
   logic              rx_pop;
   logic              rx_lost;
   logic              tx_valid;
   logic              tx_ready;
   logic [CMD_W-1:0]  tx_command;
   logic [DATA_W-1:0] tx_data;
   modport master (
      input  rx_empty, rx_command, rx_data, rx_lost, tx_ready,
      output rx_pop, tx_valid, tx_command, tx_data
   );
   modport slave (
      output rx_empty, rx_command, rx_data, rx_lost, tx_ready,
      input  rx_pop, tx_valid, tx_command, tx_data
   );
endinterface

// File: rtl/hedios_reg_bank.sv
// hedios_reg_bank: host register storage with indexed write, strobes and read mux
module hedios_reg_bank
   import hedios_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [3:0]               idx,
   input  logic [DATA_W-1:0]        wdata,
   output logic [32*NUM_REGS-1:0]   regs_flat,
   output logic [NUM_REGS-1:0]      wr_strobe,
   output logic [DATA_W-1:0]        rd_data
);
   logic [DATA_W-1:0] regs [NUM_REGS];

   // one-hot strobe; an index beyond the bank matches no entry so nothing is written
   always_comb begin
      wr_strobe = '0;
      for (int i = 0; i < NUM_REGS; i++) wr_strobe[i] = we && idx == 4'(i);
   end

   // register storage, cleared to RESET_VALUE on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) if (wr_strobe[i]) regs[i] <= wdata;
      end
   end

   // read mux driven by the same index; only consulted for in-range reads
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) if (idx == 4'(i)) rd_data = regs[i];
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[32*g +: 32] = regs[g];
   end
endmodule

// File: rtl/hedios_cmd_dispatch.sv
// hedios_cmd_dispatch: pops RX packets, executes NOP/WRITE/READ/PING, returns responses (HEDIOS_DISPATCH_WRITE_ACK_EN adds write acks)
module hedios_cmd_dispatch
   import hedios_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter logic [DATA_W-1:0] RESET_VALUE = 32'h0000_0000,
   parameter logic [CMD_W-1:0] ERR_CMD = DEF_ERR_CMD
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hedios_cmd_dispatch_if.master   bus,
   output logic [32*NUM_REGS-1:0]  regs_flat,
   output logic [NUM_REGS-1:0]     wr_strobe,
   output logic [7:0]              err_count,
   output logic                    busy
);
   state_t            state, state_n;
   logic [CMD_W-1:0]  cmd_q, tx_cmd_n;
   logic [DATA_W-1:0] data_q, tx_data_n, rd_data;
   logic [1:0]        op;
   logic              idx_ok, bad, pop, we, tx_load, dec_err;

   assign op = cmd_q[7:6];
   assign idx_ok = {1'b0, cmd_q[3:0]} < 5'(NUM_REGS);
   assign bad = (cmd_q[5:4] != 2'b00) || ((op == OP_WRITE || op == OP_READ) && !idx_ok);
   assign bus.rx_pop = pop;
   assign busy = state != S_IDLE;

   hedios_reg_bank #(.NUM_REGS(NUM_REGS), .RESET_VALUE(RESET_VALUE)) u_bank (
      .clk(clk),
      .rst_n(rst_n),
      .we(we),
      .idx(cmd_q[3:0]),
      .wdata(data_q),
      .regs_flat(regs_flat),
      .wr_strobe(wr_strobe),
      .rd_data(rd_data)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state_n;
   end

   // next state plus pop, write and response-load controls
   always_comb begin
      state_n = state;
      pop = 1'b0;
      we = 1'b0;
      tx_load = 1'b0;
      dec_err = 1'b0;
      tx_cmd_n = cmd_q;
      tx_data_n = ~data_q;
      case (state)
         S_IDLE: if (!bus.rx_empty) begin
            pop = 1'b1;
            state_n = S_LATCH;
         end
         S_LATCH: state_n = S_EXEC;
         S_EXEC: begin
            state_n = S_IDLE;
            if (bad) begin
               dec_err = 1'b1;
               tx_load = 1'b1;
               tx_cmd_n = ERR_CMD;
               tx_data_n = {24'h0, cmd_q};
               state_n = S_RESP;
            end else if (op == OP_WRITE) begin
               we = 1'b1;
`ifdef HEDIOS_DISPATCH_WRITE_ACK_EN
               tx_load = 1'b1;
               tx_data_n = data_q;
               state_n = S_RESP;
`else
               state_n = S_IDLE;
`endif
            end else if (op == OP_READ) begin
               tx_load = 1'b1;
               tx_data_n = rd_data;
               state_n = S_RESP;
            end else if (op == OP_PING) begin
               tx_load = 1'b1;
               state_n = S_RESP;
            end
         end
         S_RESP: if (bus.tx_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // packet latch, response register and saturating error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= '0;
         data_q <= '0;
         bus.tx_valid <= 1'b0;
         bus.tx_command <= '0;
         bus.tx_data <= '0;
         err_count <= '0;
      end else begin
         if (pop) begin
            cmd_q <= bus.rx_command;
            data_q <= bus.rx_data;
         end
         if (tx_load) begin
            bus.tx_valid <= 1'b1;
            bus.tx_command <= tx_cmd_n;
            bus.tx_data <= tx_data_n;
         end else if (state == S_RESP && bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
         end
         err_count <= sat_add8(err_count, {1'b0, dec_err} + {1'b0, bus.rx_lost});
      end
   end
endmodule

// File: tb/tb_hedios_cmd_dispatch.sv
// tb_hedios_cmd_dispatch: table vectors, directed corner sequences and random traffic vs. a packet-level model
module tb_hedios_cmd_dispatch;
   localparam int NR = 8;
`ifdef HEDIOS_DISPATCH_WRITE_ACK_EN
   localparam bit ACK = 1'b1;
`else
   localparam bit ACK = 1'b0;
`endif

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] data;
   } pkt_t;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] data;
      logic        resp;
      logic [7:0]  ecmd;
      logic [31:0] edata;
   } vec_t;

   logic clk, rst_n;
   logic [32*NR-1:0] regs_flat;
   logic [NR-1:0] wr_strobe;
   logic [7:0] err_count;
   logic busy;

   hedios_cmd_dispatch_if bus();

   hedios_cmd_dispatch #(.NUM_REGS(NR)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .regs_flat(regs_flat),
      .wr_strobe(wr_strobe),
      .err_count(err_count),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pkt_t rxq[$];
   pkt_t expq[$];
   logic [31:0] mregs [NR];
   int mdec, mlost, mw, wcnt, pops, resp_cnt, checks, errors, ready_mode;
   bit pop_pend, popped, lost_req, lost_rand;
   logic [7:0] last_cmd;
   logic [31:0] last_data;
   vec_t vt [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] reg_of(input int i);
      return regs_flat[32*i +: 32];
   endfunction

   function automatic int exp_err();
      return (mdec + mlost > 255) ? 255 : mdec + mlost;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mregs[i] = 32'h0;
      mdec = 0;
      mlost = 0;
      mw = 0;
      wcnt = 0;
      pop_pend = 0;
      expq.delete();
   endtask

   task automatic send(input logic [7:0] c, input logic [31:0] d);
      logic [1:0] op;
      int i;
      bit bad;
      op = c[7:6];
      i = int'(c[3:0]);
      bad = (c[5:4] != 2'b00) || ((op == 2'd1 || op == 2'd2) && i >= NR);
      rxq.push_back('{c, d});
      if (bad) begin
         mdec++;
         expq.push_back('{8'hEE, {24'h0, c}});
      end else if (op == 2'd1) begin
         mregs[i] = d;
         mw++;
         if (ACK) expq.push_back('{c, d});
      end else if (op == 2'd2) begin
         expq.push_back('{c, mregs[i]});
      end else if (op == 2'd3) begin
         expq.push_back('{c, ~d});
      end
   endtask

   task automatic step();
      pkt_t e;
      @(negedge clk);
      if (pop_pend) begin
         e = rxq.pop_front();
         pop_pend = 0;
      end
      bus.rx_empty = rxq.size() == 0;
      bus.rx_command = rxq.size() != 0 ? rxq[0].cmd : 8'h00;
      bus.rx_data = rxq.size() != 0 ? rxq[0].data : 32'h0;
      bus.tx_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode[0];
      if (lost_rand) lost_req = $urandom_range(0, 15) == 0;
      bus.rx_lost = lost_req;
      if (lost_req && rst_n) mlost++;
      #1;
      popped = bus.rx_pop;
      if (popped) begin
         pop_pend = 1;
         pops++;
      end
      for (int i = 0; i < NR; i++) if (wr_strobe[i]) wcnt++;
      if (bus.tx_valid && bus.tx_ready) begin
         resp_cnt++;
         last_cmd = bus.tx_command;
         last_data = bus.tx_data;
         if (expq.size() == 0) begin
            chk("resp_unexpected", 32'(expq.size()), 32'd1);
         end else begin
            e = expq.pop_front();
            chk("resp_cmd", 32'(bus.tx_command), 32'(e.cmd));
            chk("resp_data", bus.tx_data, e.data);
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!(rxq.size() == 0 && !pop_pend && !busy && !bus.tx_valid) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_pop(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!popped && n < budget);
      chk("pop_timeout", 32'(popped), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.tx_valid && n < budget);
      chk("valid_timeout", 32'(bus.tx_valid), 32'd1);
   endtask

   task automatic check_all();
      for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), reg_of(i), mregs[i]);
      chk("err_count", 32'(err_count), 32'(exp_err()));
      chk("wr_count", 32'(wcnt), 32'(mw));
      chk("exp_left", 32'(expq.size()), 32'd0);
   endtask

   initial begin
      int rc, pb, k;
      logic [31:0] hold_d;
      checks = 0;
      errors = 0;
      pops = 0;
      resp_cnt = 0;
      lost_req = 0;
      lost_rand = 0;
      ready_mode = 1;
      rst_n = 1'b0;
      bus.rx_empty = 1'b1;
      bus.rx_command = 8'h00;
      bus.rx_data = 32'h0;
      bus.rx_lost = 1'b0;
      bus.tx_ready = 1'b0;
      model_reset();
      vt = '{
         '{8'hC0, 32'h0000FFFF, 1'b1, 8'hC0, 32'hFFFF0000},
         '{8'h4A, 32'h00000001, 1'b1, 8'hEE, 32'h0000004A},
         '{8'h70, 32'h00000000, 1'b1, 8'hEE, 32'h00000070},
         '{8'h00, 32'h12345678, 1'b0, 8'h00, 32'h00000000},
         '{8'h8A, 32'h00000000, 1'b1, 8'hEE, 32'h0000008A},
         '{8'h87, 32'h00000000, 1'b1, 8'h87, 32'h00000000},
         '{8'h47, 32'hCAFEF00D, ACK,  8'h47, 32'hCAFEF00D},
         '{8'h87, 32'h00000000, 1'b1, 8'h87, 32'hCAFEF00D},
         '{8'hD0, 32'h00000000, 1'b1, 8'hEE, 32'h000000D0},
         '{8'h83, 32'h00000005, 1'b1, 8'h83, 32'hDEADBEEF},
         '{8'h10, 32'h00000000, 1'b1, 8'hEE, 32'h00000010}
      };

      repeat (3) step();
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_command", 32'(bus.tx_command), 32'd0);
      chk("rst_tx_data", bus.tx_data, 32'd0);
      chk("rst_rx_pop", 32'(bus.rx_pop), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check_all();
      rst_n = 1'b1;
      step();

      send(8'h43, 32'hDEADBEEF);
      wait_pop(10);
      step();
      chk("wr_latch_reg3", reg_of(3), 32'h0);
      step();
      chk("wr_exec_strobe", 32'(wr_strobe), 32'h08);
      chk("wr_exec_reg3", reg_of(3), 32'h0);
      step();
      chk("wr_done_reg3", reg_of(3), 32'hDEADBEEF);
      chk("wr_done_strobe", 32'(wr_strobe), 32'h0);
      chk("wr_done_tx_valid", 32'(bus.tx_valid), 32'(ACK));
      drain(20);

      ready_mode = 0;
      send(8'h83, 32'h0);
      send(8'h00, 32'h0);
      wait_pop(10);
      step();
      step();
      step();
      chk("rd_valid", 32'(bus.tx_valid), 32'd1);
      pb = pops;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rd_hold_valid", 32'(bus.tx_valid), 32'd1);
         chk("rd_hold_cmd", 32'(bus.tx_command), 32'h83);
         chk("rd_hold_data", bus.tx_data, 32'hDEADBEEF);
      end
      chk("rd_no_pop", 32'(pops), 32'(pb));
      chk("rd_queue_held", 32'(rxq.size()), 32'd1);
      ready_mode = 1;
      rc = resp_cnt;
      step();
      chk("rd_accepted", 32'(resp_cnt - rc), 32'd1);
      step();
      chk("rd_valid_drop", 32'(bus.tx_valid), 32'd0);
      drain(20);

      for (int v = 0; v < 11; v++) begin
         rc = resp_cnt;
         send(vt[v].cmd, vt[v].data);
         drain(40);
         chk($sformatf("vec%0d_resp_cnt", v), 32'(resp_cnt - rc), 32'(vt[v].resp));
         if (vt[v].resp) begin
            chk($sformatf("vec%0d_cmd", v), 32'(last_cmd), 32'(vt[v].ecmd));
            chk($sformatf("vec%0d_data", v), last_data, vt[v].edata);
         end
      end
      check_all();

      ready_mode = 2;
      lost_rand = 1;
      for (int i = 0; i < 200; i++) begin
         logic [1:0] bb;
         bb = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
         send({2'($urandom_range(0, 3)), bb, 4'($urandom_range(0, 15))}, $urandom);
      end
      drain(8000);
      lost_rand = 0;
      lost_req = 0;
      step();
      check_all();

      ready_mode = 0;
      send(8'h81, 32'h0);
      wait_valid(20);
      chk("mid_pre_cmd", 32'(bus.tx_command), 32'h81);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_err", 32'(err_count), 32'd0);
      for (int i = 0; i < NR; i++) chk($sformatf("mid_reg%0d", i), reg_of(i), 32'h0);
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      ready_mode = 1;
      hold_d = 32'h5;
      send(8'hC1, hold_d);
      drain(20);
      chk("post_rst_cmd", 32'(last_cmd), 32'hC1);
      chk("post_rst_data", last_data, 32'hFFFFFFFA);
      send(8'h42, 32'h77);
      send(8'h82, 32'h0);
      drain(40);
      chk("post_rst_read", last_data, 32'h77);
      check_all();

      lost_req = 1;
      send(8'h70, 32'h0);
      drain(40);
      lost_req = 0;
      step();
      chk("coincide_err", 32'(err_count), 32'(exp_err()));

      k = 254 - exp_err();
      lost_req = 1;
      repeat (k) step();
      lost_req = 0;
      step();
      chk("sat_254", 32'(err_count), 32'd254);
      lost_req = 1;
      repeat (300) step();
      lost_req = 0;
      step();
      chk("sat_255", 32'(err_count), 32'd255);
      check_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
